// File: rtl/mac_layer_scheduler_if.sv
// Result channel from the layer scheduler to its consumer: one captured
// neuron result plus its index, moved by a valid/ready handshake.
interface mac_layer_scheduler_if #(
  parameter int OUTPUT_WIDTH = 26,
  parameter int IDX_WIDTH    = 4
);
  logic [OUTPUT_WIDTH-1:0] res_data;
  logic [IDX_WIDTH-1:0]    res_idx;
  logic                    res_valid;
  logic                    res_ready;

  modport master (output res_data, output res_idx, output res_valid, input res_ready);
  modport slave  (input res_data, input res_idx, input res_valid, output res_ready);
endinterface

// File: rtl/mac_layer_scheduler.sv
// Walks one shared MAC across every neuron of a layer: clears it, waits for done,
// captures (optionally ReLU'd) results and hands them downstream one at a time.
module mac_layer_scheduler #(
  parameter int NUM_NEURONS    = 8,
  parameter int NUM_INPUTS     = 4,
  parameter int WEIGHT_WIDTH   = 19,
  parameter int OUTPUT_WIDTH   = 26,
  parameter int IDX_WIDTH      = 4,
  parameter int CAPTURE_DELAY  = 0,
  parameter int TIMEOUT_MARGIN = 8,
  parameter int RELU           = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start_i,
  output logic                                          busy_o,
  input  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_WIDTH-1:0] weights_all_i,
  output logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]             mac_weights_o,
  output logic                                          mac_rst_o,
  input  logic                                          mac_done_i,
  input  logic [OUTPUT_WIDTH-1:0]                       mac_out_i,
  mac_layer_scheduler_if.master                         res_if,
  output logic                                          layer_done_o,
  output logic                                          timeout_err_o
);
  localparam int SLICE_W   = NUM_INPUTS * WEIGHT_WIDTH;
  localparam int RUN_LIMIT = NUM_INPUTS + 1 + TIMEOUT_MARGIN;
  localparam int CNT_W     = $clog2(RUN_LIMIT + 1);
  localparam logic [CNT_W-1:0]     RUN_LAST    = CNT_W'(RUN_LIMIT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST    = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic [3:0]           SETTLE_LOAD = 4'(CAPTURE_DELAY - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, HOLD} state_e;

  state_e                  state_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [IDX_WIDTH-1:0]    res_idx_q;
  logic [CNT_W-1:0]        run_cnt_q;
  logic [3:0]              settle_cnt_q;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic [OUTPUT_WIDTH-1:0] res_data_d;
  logic                    res_valid_q;
  logic                    layer_done_q;
  logic                    timeout_err_q;
  logic                    capture;

  // ReLU inspects only the sign bit; no width change on the way through.
  assign res_data_d = (RELU != 0 && mac_out_i[OUTPUT_WIDTH-1]) ? '0 : mac_out_i;
  assign capture    = (state_q == RUN && mac_done_i && CAPTURE_DELAY == 0) ||
                      (state_q == SETTLE && settle_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      run_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      res_valid_q   <= 1'b0;
      layer_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i) begin
          idx_q         <= '0;
          timeout_err_q <= 1'b0;
          state_q       <= CLEAR;
        end
        CLEAR: begin
          run_cnt_q <= '0;
          state_q   <= RUN;
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          if (mac_done_i) begin
            if (CAPTURE_DELAY == 0) state_q <= HOLD;
            else begin
              settle_cnt_q <= SETTLE_LOAD;
              state_q      <= SETTLE;
            end
          end else if (run_cnt_q == RUN_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_q == '0) state_q <= HOLD;
          else settle_cnt_q <= settle_cnt_q - 1'b1;
        end
        HOLD: if (res_if.res_ready) begin
          res_valid_q <= 1'b0;
          if (idx_q == IDX_LAST) begin
            layer_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= CLEAR;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (capture) begin
        res_data_q  <= res_data_d;
        res_idx_q   <= idx_q;
        res_valid_q <= 1'b1;
      end
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign mac_rst_o        = rst | (state_q == CLEAR);
  assign mac_weights_o    = weights_all_i[idx_q*SLICE_W +: SLICE_W];
  assign res_if.res_data  = res_data_q;
  assign res_if.res_idx   = res_idx_q;
  assign res_if.res_valid = res_valid_q;
  assign layer_done_o     = layer_done_q;
  assign timeout_err_o    = timeout_err_q;
endmodule

// File: tb/tb_mac_layer_scheduler.sv
// Two schedulers (RELU=1/CAPTURE_DELAY=0 and RELU=0/CAPTURE_DELAY=3) share
// stimulus; each drives its own cycle-level MAC stand-in.
module tb_mac_layer_scheduler;
  localparam int NN = 8, NI = 4, WW = 19, OW = 26, IW = 4, TM = 8;
  localparam int LIMIT = NI + 1 + TM;
  localparam int SLICE = NI * WW;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst, start, res_ready, mac_kill;
  logic [NN*NI*WW-1:0] weights_all;
  int wts [NN][NI];
  int pix [NI];
  int cyc = 0;
  int checks = 0, failures = 0;

  logic [1:0]         busy_a, mrst_a, rvalid_a, ldone_a, terr_a;
  logic [1:0][OW-1:0] rdata_a;
  logic [1:0][IW-1:0] ridx_a;

  logic [OW-1:0] hs_d [2][DEPTH];
  int hs_i [2][DEPTH];
  int hs_n [2];
  int rise_c [2][DEPTH];
  int rise_n [2];
  int ld_c [2][DEPTH];
  int ld_n [2];
  logic [1:0] vprev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    weights_all = '0;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++)
        weights_all[(n*NI+i)*WW +: WW] = WW'(wts[n][i]);
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 0) ? 0 : 3;
    localparam int RL = (g == 0) ? 1 : 0;
    mac_layer_scheduler_if #(.OUTPUT_WIDTH(OW), .IDX_WIDTH(IW)) rif ();
    logic busy, mac_rst, mac_done, layer_done, timeout_err;
    logic [SLICE-1:0] mac_w;
    logic [OW-1:0] mac_out, acc;
    int step;

    mac_layer_scheduler #(
      .NUM_NEURONS(NN), .NUM_INPUTS(NI), .WEIGHT_WIDTH(WW), .OUTPUT_WIDTH(OW),
      .IDX_WIDTH(IW), .CAPTURE_DELAY(CD), .TIMEOUT_MARGIN(TM), .RELU(RL)
    ) dut (
      .clk(clk), .rst(rst), .start_i(start), .busy_o(busy),
      .weights_all_i(weights_all), .mac_weights_o(mac_w), .mac_rst_o(mac_rst),
      .mac_done_i(mac_done), .mac_out_i(mac_out), .res_if(rif),
      .layer_done_o(layer_done), .timeout_err_o(timeout_err)
    );

    assign rif.res_ready = res_ready;
    assign busy_a[g]   = busy;
    assign mrst_a[g]   = mac_rst;
    assign rvalid_a[g] = rif.res_valid;
    assign ldone_a[g]  = layer_done;
    assign terr_a[g]   = timeout_err;
    assign rdata_a[g]  = rif.res_data;
    assign ridx_a[g]   = rif.res_idx;

    // MAC stand-in: step 0 on the reset edge, one product per edge, done after edge NI+2.
    always @(posedge clk) begin
      if (mac_rst) begin
        step <= 0; acc <= '0; mac_done <= 1'b0;
      end else if (step < NI) begin
        acc  <= acc + OW'($signed(mac_w[step*WW +: WW]) * pix[step]);
        step <= step + 1;
      end else if (!mac_kill) begin
        mac_out <= acc; mac_done <= 1'b1;
      end
    end
  end

  // Record handshakes, res_valid rises and layer_done pulses with their cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rvalid_a[g] && res_ready && hs_n[g] < DEPTH) begin
        hs_d[g][hs_n[g]] <= rdata_a[g];
        hs_i[g][hs_n[g]] <= int'(ridx_a[g]);
        hs_n[g] <= hs_n[g] + 1;
      end
      if (rvalid_a[g] && !vprev[g] && rise_n[g] < DEPTH) begin
        rise_c[g][rise_n[g]] <= cyc;
        rise_n[g] <= rise_n[g] + 1;
      end
      if (ldone_a[g] && ld_n[g] < DEPTH) begin
        ld_c[g][ld_n[g]] <= cyc;
        ld_n[g] <= ld_n[g] + 1;
      end
    end
    vprev <= rvalid_a;
  end

  function automatic logic [OW-1:0] model(input int g, input int n);
    int s = 0;
    for (int i = 0; i < NI; i++) s += wts[n][i] * pix[i];
    if (g == 0 && s < 0) s = 0;
    return OW'(s);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NI; i++) begin
      case (mode)
        0: pix[i] = 2 * (i + 1);
        1: pix[i] = 1;
        default: pix[i] = int'($urandom_range(0, 7));
      endcase
      for (int n = 0; n < NN; n++) begin
        case (mode)
          0: wts[n][i] = 32'h20000;
          1: wts[n][i] = -32'sh20000;
          default: wts[n][i] = int'($urandom_range(0, (1 << WW) - 1)) - (1 << (WW - 1));
        endcase
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; mac_kill = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_a !== 2'b00 || rvalid_a !== 2'b00 || ldone_a !== 2'b00 || terr_a !== 2'b00 || mrst_a !== 2'b11) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b valid=%b done=%b terr=%b mac_rst=%b want 00 00 00 00 11",
               busy_a, rvalid_a, ldone_a, terr_a, mrst_a);
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdata_a[g] !== '0 || ridx_a[g] !== '0) begin
        failures++;
        $display("FAIL reset_data[%0d]: data=%h idx=%0d want 0 0", g, rdata_a[g], ridx_a[g]);
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mrst_a !== 2'b00 || busy_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: mac_rst=%b busy=%b want 00 00", mrst_a, busy_a);
    end
  endtask

  task automatic test_layer(input string name, input int mode, input bit rnd_ready,
                            input bit hold5, input bit poke_start);
    int hb[2], rb[2], lb[2];
    int s, exp_c, cd;
    bit done;
    logic [OW-1:0] hd;
    logic [IW-1:0] hi;
    fill(mode);
    for (int g = 0; g < 2; g++) begin hb[g] = hs_n[g]; rb[g] = rise_n[g]; lb[g] = ld_n[g]; end
    res_ready = !hold5;
    @(posedge clk); #1; start = 1'b1; s = cyc + 1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy_a !== 2'b11 || terr_a !== 2'b00) begin
      failures++;
      $display("FAIL %s_kick: busy=%b terr=%b want 11 00", name, busy_a, terr_a);
    end
    done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      if (hold5 && rvalid_a[0]) begin
        hold5 = 1'b0; hd = rdata_a[0]; hi = ridx_a[0];
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== hd || ridx_a[0] !== hi || mrst_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold: valid=%b data=%h idx=%0d mac_rst=%b want 1 %h %0d 0",
                     name, rvalid_a[0], rdata_a[0], ridx_a[0], mrst_a[0], hd, hi);
          end
        end
      end
      @(posedge clk); #1;
      if (rnd_ready && !hold5) res_ready = 1'($urandom_range(0, 1));
      start = poke_start && (t == 12);
      done = (busy_a == 2'b00);
    end
    start = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL %s_bound: busy=%b still set after cycle budget", name, busy_a);
    end
    @(negedge clk); @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      cd = (g == 0) ? 0 : 3;
      checks++;
      if (hs_n[g] - hb[g] != NN) begin
        failures++;
        $display("FAIL %s_count[%0d]: got %0d results want %0d", name, g, hs_n[g] - hb[g], NN);
      end
      for (int n = 0; n < NN; n++) begin
        checks++;
        if (hs_d[g][hb[g]+n] !== model(g, n) || hs_i[g][hb[g]+n] != n) begin
          failures++;
          $display("FAIL %s_result[%0d][%0d]: data=%h idx=%0d want %h %0d",
                   name, g, n, hs_d[g][hb[g]+n], hs_i[g][hb[g]+n], model(g, n), n);
        end
      end
      checks++;
      if (ld_n[g] - lb[g] != 1) begin
        failures++;
        $display("FAIL %s_done_count[%0d]: got %0d pulses want 1", name, g, ld_n[g] - lb[g]);
      end
      if (!rnd_ready) begin
        for (int n = 0; n < NN; n++) begin
          exp_c = s + NI + 3 + cd + n * (NI + 4 + cd);
          checks++;
          if (rise_c[g][rb[g]+n] != exp_c) begin
            failures++;
            $display("FAIL %s_latency[%0d][%0d]: valid rose at %0d want %0d",
                     name, g, n, rise_c[g][rb[g]+n], exp_c);
          end
        end
        exp_c = s + NI + 3 + cd + (NN - 1) * (NI + 4 + cd) + 1;
        checks++;
        if (ld_c[g][lb[g]] != exp_c) begin
          failures++;
          $display("FAIL %s_done_time[%0d]: pulse at %0d want %0d", name, g, ld_c[g][lb[g]], exp_c);
        end
      end
    end
    res_ready = 1'b1;
  endtask

  task automatic test_timeout();
    int hb0, lb0, lb1, s;
    int drop[2];
    drop[0] = -1; drop[1] = -1;
    hb0 = hs_n[0]; lb0 = ld_n[0]; lb1 = ld_n[1];
    mac_kill = 1'b1;
    @(posedge clk); #1; start = 1'b1; s = cyc + 1;
    @(posedge clk); #1; start = 1'b0;
    for (int t = 0; t < 100 && (drop[0] < 0 || drop[1] < 0); t++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) if (busy_a[g] == 1'b0 && drop[g] < 0) drop[g] = cyc;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (drop[g] != s + 1 + LIMIT) begin
        failures++;
        $display("FAIL timeout_time[%0d]: busy fell at %0d want %0d", g, drop[g], s + 1 + LIMIT);
      end
    end
    checks++;
    if (terr_a !== 2'b11 || busy_a !== 2'b00 || ld_n[0] != lb0 || ld_n[1] != lb1 || hs_n[0] != hb0) begin
      failures++;
      $display("FAIL timeout_state: terr=%b busy=%b done_pulses=%0d/%0d results=%0d want 11 00 0/0 0",
               terr_a, busy_a, ld_n[0] - lb0, ld_n[1] - lb1, hs_n[0] - hb0);
    end
    mac_kill = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hb0, lb0, lb1;
    fill(2);
    hb0 = hs_n[0]; lb0 = ld_n[0]; lb1 = ld_n[1];
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int t = 0; t < 200 && hs_n[0] - hb0 < 3; t++) begin @(posedge clk); #1; end
    checks++;
    if (hs_n[0] - hb0 != 3) begin
      failures++;
      $display("FAIL rstmid_reach: results=%0d want 3", hs_n[0] - hb0);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mrst_a !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_macrst: mac_rst=%b want 11", mrst_a);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 2'b00 || rvalid_a !== 2'b00 || ridx_a[0] !== '0 || rdata_a[0] !== '0) begin
      failures++;
      $display("FAIL rstmid_state: busy=%b valid=%b idx=%0d data=%h want 00 00 0 0",
               busy_a, rvalid_a, ridx_a[0], rdata_a[0]);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ld_n[0] != lb0 || ld_n[1] != lb1 || busy_a !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_nodone: done_pulses=%0d/%0d busy=%b want 0/0 00",
               ld_n[0] - lb0, ld_n[1] - lb1, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_layer("spec", 0, 1'b0, 1'b0, 1'b0);
    test_layer("neg", 1, 1'b0, 1'b0, 1'b0);
    test_layer("busy_start", 2, 1'b0, 1'b0, 1'b1);
    test_layer("backpressure", 2, 1'b1, 1'b1, 1'b0);
    test_timeout();
    test_layer("after_timeout", 2, 1'b0, 1'b0, 1'b0);
    test_reset_mid();
    test_layer("after_reset", 2, 1'b0, 1'b0, 1'b0);
    test_layer("rand_ready", 2, 1'b1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_layer_scheduler.md
Name: mac_layer_scheduler

Overview:
Sequences one shared PipelinedMultAccumulate instance across all neurons of a layer. It presents each neuron's weight vector to the MAC and restarts the MAC per neuron through its reset input. It then captures the accumulated output, optionally applies ReLU, and hands each result downstream over a valid/ready handshake. It sits between the layer weight store and the MAC; pixels go directly to the MAC and are shared by every neuron.

Parameters:
NUM_NEURONS, 8, neurons per layer (>=1)
NUM_INPUTS, 4, inputs per neuron; must match MAC NUM_INPUTS
WEIGHT_WIDTH, 19, weight width (sfix19_En18)
OUTPUT_WIDTH, 26, MAC output width (sfix26_En18)
IDX_WIDTH, 4, neuron index width; 2**IDX_WIDTH >= NUM_NEURONS
CAPTURE_DELAY, 0, extra cycles waited after mac_done before capture (0..15)
TIMEOUT_MARGIN, 8, extra cycles beyond NUM_INPUTS+1 allowed before a timeout is declared
RELU, 1, 1 = clamp negative results to 0, 0 = pass through

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  layer start request; sampled only in IDLE
busy  out  1  high in every state except IDLE
weights_all  in  NUM_NEURONS*NUM_INPUTS*WEIGHT_WIDTH  all layer weights; neuron n occupies slice [n*NUM_INPUTS*WEIGHT_WIDTH +: NUM_INPUTS*WEIGHT_WIDTH]
mac_weights  out  NUM_INPUTS*WEIGHT_WIDTH  slice of the current neuron, driven to the MAC IN_WEIGHTS port
mac_rst  out  1  MAC reset = rst OR (state==CLEAR), combinational
mac_done  in  1  MAC done
mac_out  in  OUTPUT_WIDTH  MAC OUT
res_data  out  OUTPUT_WIDTH  captured result (after ReLU if enabled)
res_idx  out  IDX_WIDTH  neuron index of res_data
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
layer_done  out  1  one-cycle pulse after the last result is accepted
timeout_err  out  1  sticky; set on timeout, cleared when the next start is accepted

Behaviour:
- Reset: state=IDLE, neuron index=0, busy=0, res_valid=0, res_data=0, res_idx=0, layer_done=0, timeout_err=0, counters=0. mac_rst is high while rst is high.
- Reset mid-operation drops any in-flight result (res_valid to 0) with no layer_done pulse.
- States: IDLE, CLEAR, RUN, SETTLE, HOLD.
- IDLE: on start, idx<=0, timeout_err<=0, go to CLEAR. start in any other state is ignored.
- CLEAR: exactly one cycle with mac_rst high; RUN/timeout counter <=0; go to RUN.
- RUN: counter increments each cycle. On mac_done: if CAPTURE_DELAY==0, capture and go to HOLD; otherwise load settle counter and go to SETTLE. If the counter reaches NUM_INPUTS+1+TIMEOUT_MARGIN without mac_done: timeout_err<=1, go to IDLE, no layer_done.
- SETTLE: count CAPTURE_DELAY cycles, then capture and go to HOLD.
- Capture (registered): res_data<=(RELU && mac_out[OUTPUT_WIDTH-1]) ? 0 : mac_out; res_idx<=idx; res_valid<=1.
- HOLD: res_data, res_idx and res_valid stay stable until res_valid&&res_ready at a clock edge. On that handshake res_valid<=0. If idx==NUM_NEURONS-1, layer_done<=1 for one cycle and go to IDLE; otherwise idx<=idx+1 and go to CLEAR.
- res_ready already high on the capture cycle: the handshake completes on the next edge, so HOLD lasts a minimum of one cycle.
- mac_weights is combinational from idx and stable from CLEAR through HOLD.
- Latency with CAPTURE_DELAY=0: res_valid rises NUM_INPUTS+3 edges after the edge that samples start. The MAC reaches step 0 at edge 1 and asserts done after edge NUM_INPUTS+2.
- Per-neuron period with res_ready held high: NUM_INPUTS+4+CAPTURE_DELAY cycles.
- Arithmetic: no width changes; ReLU looks only at the sign bit.
- NUM_NEURONS=1: a single pass, with layer_done on its handshake.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=2, res_ready=1, neuron0 weights all 0x20000 (0.5), pixels 2,4,6,8 -> res_valid 7 edges after start; res_data=10<<18; res_idx=0; then idx 1 result; layer_done pulse one cycle after the idx 1 handshake.
- res_ready held low 5 cycles on a result -> res_data, res_idx and res_valid stable throughout; no new mac_rst until the handshake completes.
- RELU=1, neuron weights -0.5, pixels 1,1,1,1 -> res_data=0. Repeat with RELU=0 -> res_data = -2.0 in sfix26_En18 (two's complement).
- mac_done tied low -> after NUM_INPUTS+1+TIMEOUT_MARGIN RUN cycles: timeout_err=1, busy=0, no layer_done. The next start clears timeout_err.
- rst asserted mid-RUN of neuron 3 -> next cycle: IDLE, res_valid=0, mac_rst high during rst. A fresh start restarts at idx 0.
- start pulsed while busy -> ignored; CAPTURE_DELAY=3 -> res_valid 3 cycles later than the CAPTURE_DELAY=0 case.
